// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ       = 8;
  localparam int IDX_W       = 3;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: the first set request at or above ptr wins, wrapping 7 -> 0.
module rr_prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotate right by ptr so that bit 0 of rot is requester ptr.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter with hold-until-release grants.
// Optional grant timeout is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import rr_arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = TIMEOUT_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  // state | meaning
  // IDLE  | no grant active; arbitrate on any request
  // BUSY  | one grant held until its requester releases (or times out)

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  rr_prio_enc8 u_enc (
    .req (req),
    .ptr (ptr),
    .idx (enc_idx),
    .any (enc_any)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (enc_any) begin
            grant       <= N_REQ'(1) << enc_idx;
            grant_idx   <= enc_idx;
            grant_valid <= 1'b1;
            ptr         <= enc_idx + IDX_W'(1);
            state       <= BUSY;
`ifdef RR_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
          end
        end
        BUSY: begin
          // A normal release wins over a timeout on the same edge.
          if (!req[grant_idx]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter; expected grants are hand-computed per step.
module tb_rr_arbiter;
  import rr_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef RR_ARB_TIMEOUT_EN
  rr_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );
`else
  rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit valid, input int idx, input bit to);
    logic [N_REQ-1:0] exp_grant;
    exp_grant = valid ? (N_REQ'(1) << idx) : '0;
    chk({tag, ".valid"}, 32'(grant_valid), 32'(valid));
    chk({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    if (valid) chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.idx", 32'(grant_idx), 32'h0);
    chk("rst.valid", 32'(grant_valid), 32'h0);
    chk("rst.timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // First grant to requester 0, then ptr=1 makes 1 beat 0
    req = 8'h01; tick(); check_out("first", 1, 0, 0);
    req = 8'h00; tick(); check_out("first_rel", 0, 0, 0);
    req = 8'h03; tick(); check_out("ptr1", 1, 1, 0);
    req = 8'h00; tick(); check_out("ptr1_rel", 0, 0, 0);

    // All requests held, each winner holds two cycles then drops
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick(); check_out($sformatf("all%0d.a", g), 1, g % 8, 0);
      tick(); check_out($sformatf("all%0d.b", g), 1, g % 8, 0);
      req = 8'hFF & ~(N_REQ'(1) << (g % 8));
      tick(); check_out($sformatf("all%0d.dead", g), 0, 0, 0);
      req = 8'hFF;
    end
    req = 8'h00;

    // Wrap: bring ptr to 7 via a grant to 6
    do_reset();
    req = 8'h40; tick(); check_out("wrap.g6", 1, 6, 0);
    req = 8'h00; tick(); check_out("wrap.rel6", 0, 0, 0);
    req = 8'h06; tick(); check_out("wrap.g1", 1, 1, 0);
    req = 8'h84; tick(); check_out("wrap.rel1", 0, 0, 0);
    tick(); check_out("wrap.g2", 1, 2, 0);
    req = 8'h80; tick(); check_out("wrap.rel2", 0, 0, 0);
    tick(); check_out("wrap.g7", 1, 7, 0);
    req = 8'h00; tick(); check_out("wrap.rel7", 0, 0, 0);

    // Holder 3 drops while 5 raises; other requests ignored while busy (ptr now 0)
    req = 8'h08; tick(); check_out("swap.g3", 1, 3, 0);
    tick(); check_out("swap.hold3", 1, 3, 0);
    req = 8'h20; tick(); check_out("swap.dead", 0, 0, 0);
    tick(); check_out("swap.g5", 1, 5, 0);
    req = 8'h21; tick(); check_out("swap.ignore", 1, 5, 0);
    req = 8'h00; tick(); check_out("swap.rel5", 0, 0, 0);

    // Reset mid-grant with holder 4 (ptr 6 scans round to 4)
    req = 8'h10; tick(); check_out("mid.g4", 1, 4, 0);
    #2 rst = 1'b1;
    #1 check_out("mid.async", 0, 0, 0);
    req = 8'h11;
    tick();
    rst = 1'b0;
    check_out("mid.held", 0, 0, 0);
    tick(); check_out("mid.g0", 1, 0, 0);
    req = 8'h00; tick(); check_out("mid.rel0", 0, 0, 0);

`ifdef RR_ARB_TIMEOUT_EN
    // TIMEOUT=4: requester 0 held 4 cycles, revoked, dead cycle, then 1
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      tick(); check_out($sformatf("to.g0_%0d", c), 1, 0, 0);
    end
    tick(); check_out("to.revoke", 0, 0, 1);
    tick(); check_out("to.g1", 1, 1, 0);
    req = 8'h01; tick(); check_out("to.rel1", 0, 0, 0);
`else
    // Without the timeout option, a grant is held indefinitely
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 20; c++) begin
      tick(); check_out($sformatf("hold.g0_%0d", c), 1, 0, 0);
    end
    req = 8'h02; tick(); check_out("hold.rel0", 0, 0, 0);
    tick(); check_out("hold.g1", 1, 1, 0);
`endif

    req = 8'h00;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Eight-way round-robin arbiter that shares one downstream resource (e.g. a bus or datapath lane) among eight requesters. Each cycle it scans the request vector with a rotating-priority encoder, grants exactly one requester, holds the grant until that requester releases, then advances priority past the winner. It sits between the requester agents and the shared resource's select input, and supplies both a one-hot grant and the binary-encoded winner index.

## Interface
- `N_REQ`, 8: number of requesters; fixed at 8 for this revision.
- `IDX_W`, 3: width of the encoded grant index, log2(N_REQ).
- `TIMEOUT`, 16: maximum grant length in cycles; used only when `RR_ARB_TIMEOUT_EN` is defined. Legal range is 2..256.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector; bit i is high while requester i wants or holds the resource.
- `grant`  out  8  one-hot grant, registered; all-zero when idle.
- `grant_idx`  out  3  binary index of the granted requester, registered; valid only while `grant_valid` is high.
- `grant_valid`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States:
  - IDLE: no grant is active.
  - BUSY: one grant is active.
- Reset values:
  - state = IDLE; `grant` = 8'b0; `grant_idx` = 3'b0; `grant_valid` = 0; `timeout` = 0.
  - Priority pointer `ptr` = 0, so requester 0 has highest priority first.
- IDLE behaviour:
  - If `req` != 0, select the first set bit scanning upward from `ptr`, wrapping from 7 to 0.
  - Register the grant and go to BUSY.
  - Set `ptr` = winner + 1 mod 8 (wrap 7 -> 0).
- BUSY behaviour:
  - While `req[grant_idx]` = 1, hold the grant unchanged. Other request bits are ignored.
  - When `req[grant_idx]` = 0 is sampled, clear the grant and go to IDLE.
  - No re-arbitration occurs in the release cycle.
- A requester that drops and re-raises its request competes normally; it has the lowest priority because `ptr` has already advanced past it.
- If all eight requests are asserted continuously, the grant order is 0,1,2,…,7,0,…
- Invariant: `grant` = 1 << `grant_idx` whenever `grant_valid` = 1.
- Invariant: `grant` is never multi-hot.

## Timing
- Grant latency: `req` sampled at edge k -> `grant` visible after edge k.
- Release: `req` low sampled at edge m -> `grant` cleared after edge m.
- Turnaround: the next grant appears after edge m+1, giving one dead cycle between grants.
- Minimum grant length is one cycle (request dropped immediately after grant).
- Reset mid-grant: outputs and `ptr` clear asynchronously; the first grant after reset deassertion follows the IDLE rules with `ptr` = 0.
- Requests that change during the release cycle are sampled at edge m+1 only.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter of $clog2(TIMEOUT) bits clears on entry to BUSY and increments every BUSY cycle.
  - If the counter reaches TIMEOUT-1 and `req[grant_idx]` is still 1, the grant is cleared at that edge, `timeout` pulses high for one cycle, and the state goes to IDLE.
  - The revoked requester keeps the lowest priority through the pointer rule.
  - A normal release on the same edge takes precedence, and `timeout` stays 0.
- Undefined: no counter is built, `timeout` is tied to 0, and grants are unbounded.

## Structure
- Shared package `rr_arb_pkg`:
  - N_REQ and IDX_W constants.
  - State enum: IDLE = 1'b0, BUSY = 1'b1.
  - TIMEOUT default constant.
- Sub-module `rr_prio_enc8`: combinational rotating priority encoder.
  - Inputs: 8-bit request and 3-bit `ptr`.
  - Outputs: 3-bit index and `any` flag.
  - Implementation: rotate, fixed-priority encode, add back `ptr` mod 8.
- Top level holds the FSM, `ptr`, output registers and the optional timeout counter.

## Test plan
- Reset, then `req` = 8'b0000_0001 -> `grant` = 8'h01 and `grant_idx` = 0 one edge later; `ptr` = 1.
- `req` = 8'hFF held continuously, each winner releasing after 2 cycles -> `grant_idx` sequence 0,1,…,7,0 with one idle cycle between grants.
- Wrap: `ptr` = 7 and `req` = 8'b0000_0110 -> winner 1; then `req` = 8'b1000_0100 -> winner 2, then winner 7 after release.
- Release and new request in the same cycle: holder 3 drops while 5 raises -> one dead cycle, then `grant_idx` = 5.
- Assert `rst` mid-grant (holder 4) -> outputs go to 0 immediately; after reset, `req` = 8'b0001_0001 -> winner 0.
- `RR_ARB_TIMEOUT_EN`, `TIMEOUT` = 4, `req` = 8'b0000_0011 held -> requester 0 is granted for 4 cycles, `timeout` pulses once, then one idle cycle, then requester 1 is granted.
